dram_slot_arb: RTL

Slot-based arbiter for the shared 16-bit DRAM port used by the Z80 memory manager, video fetch, DMA and tile/sprite (TS) engines. On every slot boundary it picks one owner for the next DRAM slot. It issues that owner's command to the DRAM controller and routes the returned read strobes to the right requester. It produces the `cpu_next`, `cpu_strobe` and `cpu_latch` handshake that the Z80 memory manager uses for wait-state and stall generation.

---
 rtl/dram_arb_pkg.sv | 18 +
 rtl/owner_fifo.sv | 60 ++++++
 rtl/dram_slot_arb.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dram_arb_pkg.sv
// rtl/dram_arb_pkg.sv - shared owner encoding, address width and byte-select constants for the DRAM slot arbiter
package dram_arb_pkg;

    typedef enum logic [2:0] {
        OWN_NONE = 3'd0,
        OWN_VID  = 3'd1,
        OWN_CPU  = 3'd2,
        OWN_DMA  = 3'd3,
        OWN_TS   = 3'd4
    } owner_t;

    localparam int AW_DEF = 21;

    localparam logic [1:0] BSEL_LO   = 2'b01;
    localparam logic [1:0] BSEL_HI   = 2'b10;
    localparam logic [1:0] BSEL_WORD = 2'b11;

endpackage

// File: rtl/owner_fifo.sv
// rtl/owner_fifo.sv - in-order FIFO of read owners awaiting their DRAM return strobe
module owner_fifo
    import dram_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  owner_t                         push_data,
    input  logic                           pop,
    output owner_t                         head,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    owner_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // a pop in the same clock frees the slot a push into a full FIFO needs
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dram_slot_arb.sv
// rtl/dram_slot_arb.sv - slot arbiter for the shared DRAM port: grant at c3, command register, read-return routing
module dram_slot_arb
    import dram_arb_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int STARVE   = 8,
    parameter int RQ_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c3,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_wr,
    input  logic [15:0]   cpu_wrdata,
    input  logic          cpu_wrbsel,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_addr,
    input  logic          dma_wr,
    input  logic [15:0]   dma_wrdata,
    input  logic          ts_req,
    input  logic [AW-1:0] ts_addr,
    output logic          cpu_next,
    output logic          cpu_strobe,
    output logic          cpu_latch,
    output logic          vid_strobe,
    output logic          dma_strobe,
    output logic          ts_strobe,
    output logic          dma_next,
    output logic          ts_next,
    output logic          dram_req,
    output logic [AW-1:0] dram_addr,
    output logic          dram_wr,
    output logic [15:0]   dram_wrdata,
    output logic [1:0]    dram_bsel,
    input  logic          dram_rdstb,
    output logic          ret_err
);

    localparam int CW = $clog2(STARVE+1);
    localparam int QW = $clog2(RQ_DEPTH+1);

    owner_t          grant;
    owner_t          cmd_owner;
    owner_t          rr_ptr;
    owner_t          q_head;
    logic [QW-1:0]   q_count;
    logic            q_full;
    logic            q_empty;
    logic [CW-1:0]   dma_cnt;
    logic [CW-1:0]   ts_cnt;
    logic            latch_q;
    logic            pend_rd;
    logic            rd_block;
    logic            rd_hit;
    logic            vid_ok, cpu_ok, dma_ok, ts_ok;
    logic            dma_starved, ts_starved;
    owner_t          rr_pick;

    // a read issued this clock is pushed now but not yet in count
    assign pend_rd  = dram_req && !dram_wr;
    assign rd_block = q_full || (pend_rd && q_count == QW'(RQ_DEPTH-1));

    assign vid_ok = vid_req && !rd_block;
    assign cpu_ok = cpu_req && (cpu_wr || !rd_block);
    assign dma_ok = dma_req && (dma_wr || !rd_block);
    assign ts_ok  = ts_req && !rd_block;

    assign dma_starved = (dma_cnt >= CW'(STARVE));
    assign ts_starved  = (ts_cnt >= CW'(STARVE));
    assign rr_pick     = (rr_ptr == OWN_DMA) ? OWN_DMA : OWN_TS;

    always_comb begin
        grant = OWN_NONE;
        if (vid_ok)
            grant = OWN_VID;
        else if (dma_ok && dma_starved && ts_ok && ts_starved)
            grant = rr_pick;
        else if (dma_ok && dma_starved)
            grant = OWN_DMA;
        else if (ts_ok && ts_starved)
            grant = OWN_TS;
        else if (cpu_ok)
            grant = OWN_CPU;
        else if (dma_ok && ts_ok)
            grant = rr_pick;
        else if (dma_ok)
            grant = OWN_DMA;
        else if (ts_ok)
            grant = OWN_TS;
    end

    assign dma_next = c3 && (grant == OWN_DMA);
    assign ts_next  = c3 && (grant == OWN_TS);
    assign cpu_next = !vid_req && !rst;

    assign rd_hit     = dram_rdstb && !q_empty;
    assign vid_strobe = rd_hit && (q_head == OWN_VID);
    assign cpu_strobe = rd_hit && (q_head == OWN_CPU);
    assign dma_strobe = rd_hit && (q_head == OWN_DMA);
    assign ts_strobe  = rd_hit && (q_head == OWN_TS);
    assign cpu_latch  = latch_q || cpu_strobe;

    owner_fifo #(.DEPTH(RQ_DEPTH)) u_owner_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pend_rd),
        .push_data (cmd_owner),
        .pop       (rd_hit),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dram_req    <= 1'b0;
            dram_addr   <= '0;
            dram_wr     <= 1'b0;
            dram_wrdata <= '0;
            dram_bsel   <= '0;
            cmd_owner   <= OWN_NONE;
            rr_ptr      <= OWN_DMA;
            dma_cnt     <= '0;
            ts_cnt      <= '0;
            latch_q     <= 1'b0;
            ret_err     <= 1'b0;
        end else begin
            dram_req <= 1'b0;
            if (dram_rdstb && q_empty)
                ret_err <= 1'b1;

            if (cpu_strobe)
                latch_q <= 1'b1;
            else if (c3 && (!cpu_req || grant == OWN_CPU))
                latch_q <= 1'b0;

            if (c3) begin
                if (grant != OWN_NONE) begin
                    dram_req  <= 1'b1;
                    cmd_owner <= grant;
                end
                case (grant)
                    OWN_VID: begin
                        dram_addr   <= vid_addr;
                        dram_wr     <= 1'b0;
                        dram_wrdata <= '0;
                        dram_bsel   <= BSEL_WORD;
                    end
                    OWN_CPU: begin
                        // the CPU byte is replicated; bsel picks which lane DRAM writes
                        dram_addr   <= cpu_addr;
                        dram_wr     <= cpu_wr;
                        dram_wrdata <= cpu_wr ? {cpu_wrdata[7:0], cpu_wrdata[7:0]} : 16'h0000;
                        dram_bsel   <= !cpu_wr ? BSEL_WORD : (cpu_wrbsel ? BSEL_HI : BSEL_LO);
                    end
                    OWN_DMA: begin
                        dram_addr   <= dma_addr;
                        dram_wr     <= dma_wr;
                        dram_wrdata <= dma_wr ? dma_wrdata : 16'h0000;
                        dram_bsel   <= BSEL_WORD;
                        rr_ptr      <= OWN_TS;
                    end
                    OWN_TS: begin
                        dram_addr   <= ts_addr;
                        dram_wr     <= 1'b0;
                        dram_wrdata <= '0;
                        dram_bsel   <= BSEL_WORD;
                        rr_ptr      <= OWN_DMA;
                    end
                    default: ;
                endcase

                if (!dma_req || grant == OWN_DMA)
                    dma_cnt <= '0;
                else if (dma_cnt < CW'(STARVE))
                    dma_cnt <= dma_cnt + 1'b1;

                if (!ts_req || grant == OWN_TS)
                    ts_cnt <= '0;
                else if (ts_cnt < CW'(STARVE))
                    ts_cnt <= ts_cnt + 1'b1;
            end
        end
    end

endmodule
